// File: rtl/smi_mem_if.sv
// SMI request/response link between a requester (arbiter side) and the
// memory responder. Request flits flow master->slave, response flits flow
// slave->master; each direction has its own Ready/Stop handshake.
interface smi_mem_if #(
   parameter int DataWidth = 64
);
   logic                 smiReqInReady;
   logic [7:0]           smiReqInEofc;
   logic [DataWidth-1:0] smiReqInData;
   logic                 smiReqInStop;
   logic                 smiRespOutReady;
   logic [7:0]           smiRespOutEofc;
   logic [DataWidth-1:0] smiRespOutData;
   logic                 smiRespOutStop;

   modport master (
      output smiReqInReady, smiReqInEofc, smiReqInData, smiRespOutStop,
      input  smiReqInStop, smiRespOutReady, smiRespOutEofc, smiRespOutData
   );

   modport slave (
      input  smiReqInReady, smiReqInEofc, smiReqInData, smiRespOutStop,
      output smiReqInStop, smiRespOutReady, smiRespOutEofc, smiRespOutData
   );
endinterface

// File: rtl/smi_mem_responder.sv
// SMI memory endpoint: terminates request frames (read/write) against an
// internal single-port word RAM and returns response frames. Reads go
// through a registered RAM output plus a 2-entry skid buffer so data is
// never lost under response backpressure.
module smi_mem_responder #(
   parameter int FlitWidth = 8,
   parameter int AddrWidth = 10
) (
   input  logic      clk,
   input  logic      arst_n,
   smi_mem_if.slave  smi
);
   localparam int DataWidth = FlitWidth * 8;
   localparam int OffW      = $clog2(FlitWidth);

   typedef enum logic [2:0] {IDLE, WR_DATA, DRAIN, RESP, RD_HDR, RD_DATA} state_e;

   state_e                        state_q, state_d;
   logic                          init_q;
   logic [7:0]                    len_q, len_d;
   logic [7:0]                    status_q, status_d;
   logic [15:0]                   tag_q, tag_d;
   logic [AddrWidth-1:0]          idx_q, idx_d;
   logic [8:0]                    cnt_q, cnt_d;      // flits written / reads issued
   logic [1:0][DataWidth-1:0]     sk_data_q, sk_data_d;
   logic [1:0]                    sk_last_q, sk_last_d;
   logic                          sk_wp_q, sk_wp_d, sk_rp_q, sk_rp_d;
   logic [1:0]                    sk_cnt_q, sk_cnt_d;
   logic                          rd_pend_q, rd_pend_d;  // ram_rdata_q holds a fresh word
   logic                          rd_last_q, rd_last_d;
   logic [DataWidth-1:0]          ram_rdata_q;
   logic [DataWidth-1:0]          mem [2**AddrWidth];

   logic                          req_fire, we, rd_issue, pop, push, pop_sk;
   logic                          head_vld, head_last;
   logic [DataWidth-1:0]          head_data;
   logic [FlitWidth-1:0]          be;
   logic [7:0]                    op, eofc_in;
   logic [31:0]                   haddr;
   logic                          resp_ready;
   logic [7:0]                    resp_eofc;
   logic [DataWidth-1:0]          resp_data;
   logic                          unused_req_bits;

   assign op       = smi.smiReqInData[7:0];
   assign haddr    = smi.smiReqInData[63:32];
   assign eofc_in  = smi.smiReqInEofc;
   assign req_fire = smi.smiReqInReady && !smi.smiReqInStop;
   assign unused_req_bits = ^smi.smiReqInData;

   // Requests are held off until one cycle after reset and whenever a response is owed.
   assign smi.smiReqInStop    = !init_q || (state_q inside {RESP, RD_HDR, RD_DATA});
   assign smi.smiRespOutReady = resp_ready;
   assign smi.smiRespOutEofc  = resp_eofc;
   assign smi.smiRespOutData  = resp_data;

   // Read-path head: oldest skid entry first, else bypass the fresh RAM word.
   assign head_vld  = (sk_cnt_q != 2'd0) || rd_pend_q;
   assign head_data = (sk_cnt_q != 2'd0) ? sk_data_q[sk_rp_q] : ram_rdata_q;
   assign head_last = (sk_cnt_q != 2'd0) ? sk_last_q[sk_rp_q] : rd_last_q;

   // Next-state, datapath control and response outputs.
   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      status_d  = status_q;
      tag_d     = tag_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      sk_data_d = sk_data_q;
      sk_last_d = sk_last_q;
      sk_wp_d   = sk_wp_q;
      sk_rp_d   = sk_rp_q;
      sk_cnt_d  = sk_cnt_q;
      rd_pend_d = 1'b0;
      rd_last_d = rd_last_q;
      we        = 1'b0;
      be        = '1;
      rd_issue  = 1'b0;
      pop       = 1'b0;
      push      = 1'b0;
      pop_sk    = 1'b0;
      resp_ready = 1'b0;
      resp_eofc  = 8'd0;
      resp_data  = '0;
      case (state_q)
         IDLE: if (req_fire) begin
            len_d    = smi.smiReqInData[15:8];
            tag_d    = smi.smiReqInData[31:16];
            idx_d    = haddr[AddrWidth+OffW-1:OffW];
            cnt_d    = 9'd0;
            status_d = 8'h00;
            if (op == 8'h02) begin
               if (eofc_in == 8'd0) state_d = WR_DATA;
               else begin status_d = 8'h03; state_d = RESP; end
            end else if (op == 8'h01) begin
               if (eofc_in != 8'd0) state_d = RD_HDR;
               else begin status_d = 8'h03; state_d = DRAIN; end
            end else begin
               status_d = 8'h01;
               state_d  = (eofc_in != 8'd0) ? RESP : DRAIN;
            end
         end
         WR_DATA: if (req_fire) begin
            we    = 1'b1;
            idx_d = idx_q + 1'b1;
            cnt_d = cnt_q + 9'd1;
            if (eofc_in != 8'd0) begin
               for (int b = 0; b < FlitWidth; b++) be[b] = (8'(b) < eofc_in);
               status_d = (cnt_q == {1'b0, len_q}) ? 8'h00 : 8'h03;
               state_d  = RESP;
            end else if (cnt_q == {1'b0, len_q}) begin
               // Frame is longer than announced: keep what fits, drop the rest.
               status_d = 8'h03;
               state_d  = DRAIN;
            end
         end
         DRAIN: if (req_fire && eofc_in != 8'd0) state_d = RESP;
         RESP: begin
            resp_ready = 1'b1;
            resp_eofc  = 8'(FlitWidth);
            resp_data[31:0] = {tag_q, len_q, status_q};
            if (!smi.smiRespOutStop) state_d = IDLE;
         end
         RD_HDR: begin
            resp_ready = 1'b1;
            resp_data[31:0] = {tag_q, len_q, status_q};
            if (!smi.smiRespOutStop) begin
               state_d  = RD_DATA;
               rd_issue = 1'b1;
            end
         end
         RD_DATA: begin
            resp_ready = head_vld;
            resp_eofc  = head_last ? 8'(FlitWidth) : 8'd0;
            resp_data  = head_data;
            pop    = head_vld && !smi.smiRespOutStop;
            pop_sk = pop && (sk_cnt_q != 2'd0);
            push   = rd_pend_q && !(pop && (sk_cnt_q == 2'd0));
            if (push) begin
               sk_data_d[sk_wp_q] = ram_rdata_q;
               sk_last_d[sk_wp_q] = rd_last_q;
               sk_wp_d = ~sk_wp_q;
            end
            if (pop_sk) sk_rp_d = ~sk_rp_q;
            sk_cnt_d = sk_cnt_q + {1'b0, push} - {1'b0, pop_sk};
            // Only issue when next cycle's RAM word is guaranteed a skid slot.
            if (cnt_q <= {1'b0, len_q} && sk_cnt_d < 2'd2) rd_issue = 1'b1;
            if (pop && head_last) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (rd_issue) begin
         rd_pend_d = 1'b1;
         rd_last_d = (cnt_q == {1'b0, len_q});
         cnt_d     = cnt_q + 9'd1;
         idx_d     = idx_q + 1'b1;
      end
   end

   // Control and skid-buffer state registers.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= IDLE;
         init_q    <= 1'b0;
         len_q     <= '0;
         status_q  <= '0;
         tag_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         sk_data_q <= '0;
         sk_last_q <= '0;
         sk_wp_q   <= 1'b0;
         sk_rp_q   <= 1'b0;
         sk_cnt_q  <= '0;
         rd_pend_q <= 1'b0;
         rd_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         init_q    <= 1'b1;
         len_q     <= len_d;
         status_q  <= status_d;
         tag_q     <= tag_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         sk_data_q <= sk_data_d;
         sk_last_q <= sk_last_d;
         sk_wp_q   <= sk_wp_d;
         sk_rp_q   <= sk_rp_d;
         sk_cnt_q  <= sk_cnt_d;
         rd_pend_q <= rd_pend_d;
         rd_last_q <= rd_last_d;
      end
   end

   // Byte-enabled RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < FlitWidth; b++)
         if (we && be[b]) mem[idx_q][b*8 +: 8] <= smi.smiReqInData[b*8 +: 8];
   end

   // Registered RAM read port.
   always_ff @(posedge clk) begin
      if (rd_issue) ram_rdata_q <= mem[idx_q];
   end
endmodule

// File: doc/smi_mem_responder.md
Name: smi_mem_responder

Overview:
- Memory-side endpoint of the SMI transaction path. It terminates the request frames that the transaction arbiters emit downstream and returns response frames on the same interface.
- Backed by an internal single-port word RAM, one word per flit.
- Used as an on-chip target for arbiter and matcher integration and as a small scratchpad behind an arbiter tree.

Parameters:
- FlitWidth, 8, bytes per flit; minimum 8; must be a power of two.
- AddrWidth, 10, log2 of RAM depth in flits.
- DataWidth, FlitWidth*8, derived data bus width.

Ports:
- clk  input  1  clock.
- arst_n  input  1  asynchronous active-low reset.
- smiReqInReady  input  1  request flit valid.
- smiReqInEofc  input  8  0 = not last; 1..FlitWidth = last flit, valid byte count.
- smiReqInData  input  DataWidth  request flit.
- smiReqInStop  output  1  backpressure to requester.
- smiRespOutReady  output  1  response flit valid.
- smiRespOutEofc  output  8  response end-of-frame count.
- smiRespOutData  output  DataWidth  response flit.
- smiRespOutStop  input  1  backpressure from response sink.

Behaviour:
- Clock and reset:
  - One clock domain, clk.
  - Reset is asynchronous and active-low on arst_n.
  - On reset: state IDLE, smiRespOutReady=0, smiRespOutEofc=0, smiRespOutData=0, smiReqInStop=1, skid buffer empty.
  - smiReqInStop deasserts the first cycle after reset release.
  - RAM contents are not reset.
- Handshake:
  - A flit transfers when Ready=1 and Stop=0 in the same cycle.
  - Once the responder asserts Ready, Ready/Eofc/Data are held stable until the flit transfers.
- Request header (first flit of every frame):
  - [7:0] opcode: 0x01 read, 0x02 write.
  - [15:8] len: number of data flits minus 1, giving 1..256 flits.
  - [31:16] tag.
  - [63:32] byte address.
  - The word index is addr[AddrWidth+log2(FlitWidth)-1 : log2(FlitWidth)]. Upper bits are ignored and the low byte offset is ignored.
  - The word index increments per flit and wraps modulo 2^AddrWidth.
- Response header:
  - [7:0] status: 0x00 OK, 0x01 bad opcode, 0x03 length mismatch.
  - [15:8] len echoed.
  - [31:16] tag echoed.
  - [63:32] zero.
- States:
  - IDLE: accept header. Opcode 0x02 -> WR_DATA. Opcode 0x01 with header eofc!=0 -> RD_HDR. Any other opcode, or a write header with eofc!=0 -> DRAIN, or directly RESP if eofc!=0.
  - WR_DATA: each accepted flit writes RAM at the current index.
    - A non-last flit writes all bytes.
    - A last flit writes only bytes [eofc-1:0].
    - Count reaching len+1 together with eofc!=0 -> RESP with status 0x00.
    - eofc!=0 arriving early -> RESP with status 0x03; flits already received stay written.
    - Count exceeding len+1 without eofc -> DRAIN with status 0x03, no further writes.
  - DRAIN: discard flits until eofc!=0, then -> RESP.
  - RESP: emit one header flit with eofc=FlitWidth, then -> IDLE. smiReqInStop=1 while in this state.
  - RD_HDR: emit header with status 0x00 and eofc=0, then -> RD_DATA.
  - RD_DATA: issue RAM reads with a 1-cycle registered latency into a 2-entry skid buffer.
    - A read is issued only when the skid buffer will have a free slot, so no flit is lost under Stop.
    - Data flits carry eofc=0, except the (len+1)th flit, which carries eofc=FlitWidth.
    - After the last flit transfers -> IDLE.
  - A read header with eofc=0 (trailing flits) -> DRAIN, then RESP with status 0x03 and no data.
- Stop and ordering:
  - smiReqInStop=1 in RESP, RD_HDR and RD_DATA. Requests are processed strictly in order, one at a time.
  - Read-after-write to the same address returns the new data.
- Throughput:
  - Writes: 1 flit/cycle.
  - Reads: 1 flit/cycle when Stop=0, with the first data flit one cycle after the header transfers.
  - Write latency: last data flit accepted -> ack Ready on the next cycle.
- Reset mid-frame: abandon the transaction, emit no response, RAM keeps partial writes.

Test Plan:
- Write then read, same address:
  - Stimulus: write opcode 0x02, len=3, tag=0x1234, addr=0x40, data 0x11..,0x22..,0x33..,0x44.., last eofc=8. Then read the same address.
  - Response: ack status 0x00 with tag 0x1234, eofc=8. Read returns header plus 4 flits in order, eofc=0,0,0,8.
- Partial last flit: write len=0 with eofc=3 and data 0xFFFF..FF over a word preset to 0 -> readback 0x0000000000FFFFFF.
- Wrap-around: AddrWidth=4, addr=15*8, write len=1 -> flits land at indices 15 then 0; readback from index 0 returns the second flit.
- Backpressure: read len=7 with smiRespOutStop toggled with a random 50% pattern -> all 8 flits delivered exactly once, in order. Ready/Data hold stable while Stop=1.
- Errors:
  - Opcode 0x7F with 3 trailing flits -> flits drained, single ack with status 0x01.
  - Write len=3 ending after 2 flits -> status 0x03.
- Async reset mid-read: assert arst_n=0 during RD_DATA -> smiRespOutReady=0 immediately. After release, a new request is served normally.
